// File: rtl/jt12_mixacc_if.sv
// Slot-stream input and frame-output bundle for jt12_mixacc.
// master drives the operator stream, slave is the accumulator.
interface jt12_mixacc_if #(
  parameter int WIN   = 14,
  parameter int WOUT  = 16,
  parameter int CH    = 6,
  parameter int PCM_W = 9
);
  logic                    clk_en;
  logic                    zero;
  logic signed [WIN-1:0]   op_result;
  logic [1:0]              rl;
  logic [2:0]              alg;
  logic [CH-1:0]           ch_mute;
  logic                    pcm_en;
  logic signed [PCM_W-1:0] pcm;
  logic signed [WOUT-1:0]  left;
  logic signed [WOUT-1:0]  right;
  logic                    sample_valid;
  logic                    clip_l;
  logic                    clip_r;

  modport master (
    output clk_en, zero, op_result, rl, alg, ch_mute, pcm_en, pcm,
    input  left, right, sample_valid, clip_l, clip_r
  );
  modport slave (
    input  clk_en, zero, op_result, rl, alg, ch_mute, pcm_en, pcm,
    output left, right, sample_valid, clip_l, clip_r
  );
endinterface

// File: rtl/jt12_mixacc.sv
// Stereo per-frame accumulator of carrier operators with PCM substitution,
// saturating adds and optional output gain; one L/R pair per frame.
module jt12_mixacc #(
  parameter int WIN    = 14,
  parameter int WOUT   = 16,
  parameter int CH     = 6,
  parameter int OPS    = 4,
  parameter int PCM_CH = 5,
  parameter int PCM_W  = 9,
  parameter int GAIN   = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  jt12_mixacc_if.slave  bus
);
  localparam int SLOTS = CH * OPS;
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int GSH   = (GAIN == 2) ? 1 : 2;
  localparam logic signed [WOUT-1:0] VMAX = {1'b0, {(WOUT-1){1'b1}}};
  localparam logic signed [WOUT-1:0] VMIN = {1'b1, {(WOUT-1){1'b0}}};

  // {clip, value}
  function automatic logic [WOUT:0] sat_add(input logic signed [WOUT-1:0] a,
                                            input logic signed [WOUT-1:0] b);
    logic signed [WOUT:0] sum;
    sum = {a[WOUT-1], a} + {b[WOUT-1], b};
    if (sum[WOUT] != sum[WOUT-1]) return {1'b1, sum[WOUT] ? VMIN : VMAX};
    return {1'b0, sum[WOUT-1:0]};
  endfunction

  logic [SW-1:0] s, cur, op_idx, ch_idx;
  logic          sum_en, is_pcm;
  logic signed [WIN-1:0]  pcm_sh, contrib;
  logic signed [WOUT-1:0] contrib_w, add_l, add_r;
  logic [WOUT:0]          sum_l, sum_r, gn_l, gn_r;

  logic signed [WOUT-1:0] acc_l, acc_r, st_l, st_r, g_l, g_r;
  logic                   clp_l, clp_r, st_cl, st_cr, g_cl, g_cr;
  logic [1:0]             vld_pipe;

  // zero forces the current slot to 0 regardless of where the counter is
  assign cur    = bus.zero ? '0 : s;
  assign op_idx = cur / SW'(CH);
  assign ch_idx = cur % SW'(CH);

  always_comb begin
    sum_en = 1'b1;
    if (!bus.alg[2]) begin
      sum_en = (op_idx == SW'(OPS-1));
    end else if (OPS == 4) begin
      case (bus.alg)
        3'd4:       sum_en = (op_idx == SW'(2)) || (op_idx == SW'(3));
        3'd5, 3'd6: sum_en = (op_idx != '0);
        default:    sum_en = 1'b1;
      endcase
    end
  end

  assign is_pcm = bus.pcm_en && (ch_idx == SW'(PCM_CH));
  assign pcm_sh = WIN'(bus.pcm) <<< (WIN - PCM_W);

  always_comb begin
    contrib = '0;
    if (!bus.ch_mute[ch_idx]) begin
      if (is_pcm)      contrib = (op_idx == '0) ? pcm_sh : '0;
      else if (sum_en) contrib = bus.op_result;
    end
  end

  assign contrib_w = WOUT'(contrib);
  assign add_l     = bus.rl[1] ? contrib_w : '0;
  assign add_r     = bus.rl[0] ? contrib_w : '0;
  assign sum_l     = sat_add(acc_l, add_l);
  assign sum_r     = sat_add(acc_r, add_r);
  assign gn_l      = (GAIN == 0) ? {1'b0, st_l} : sat_add(st_l, st_l >>> GSH);
  assign gn_r      = (GAIN == 0) ? {1'b0, st_r} : sat_add(st_r, st_r >>> GSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s        <= '0;
      acc_l    <= '0;
      acc_r    <= '0;
      clp_l    <= 1'b0;
      clp_r    <= 1'b0;
      st_l     <= '0;
      st_r     <= '0;
      st_cl    <= 1'b0;
      st_cr    <= 1'b0;
      g_l      <= '0;
      g_r      <= '0;
      g_cl     <= 1'b0;
      g_cr     <= 1'b0;
      vld_pipe <= '0;
    end else if (bus.clk_en) begin
      if (bus.zero) begin
        s     <= (SLOTS > 1) ? SW'(1) : '0;
        st_l  <= acc_l;
        st_r  <= acc_r;
        st_cl <= clp_l;
        st_cr <= clp_r;
        // a single contribution can never overflow, so the reload is clip-free
        acc_l <= add_l;
        acc_r <= add_r;
        clp_l <= 1'b0;
        clp_r <= 1'b0;
      end else begin
        s     <= (s == SW'(SLOTS-1)) ? '0 : s + SW'(1);
        acc_l <= sum_l[WOUT-1:0];
        acc_r <= sum_r[WOUT-1:0];
        clp_l <= clp_l | sum_l[WOUT];
        clp_r <= clp_r | sum_r[WOUT];
      end
      vld_pipe <= {vld_pipe[0], bus.zero};
      g_l      <= gn_l[WOUT-1:0];
      g_r      <= gn_r[WOUT-1:0];
      g_cl     <= st_cl | gn_l[WOUT];
      g_cr     <= st_cr | gn_r[WOUT];
    end
  end

  // valid is a single clk pulse even when clk_en stays low afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.left         <= '0;
      bus.right        <= '0;
      bus.clip_l       <= 1'b0;
      bus.clip_r       <= 1'b0;
      bus.sample_valid <= 1'b0;
    end else begin
      bus.sample_valid <= bus.clk_en & vld_pipe[1];
      if (bus.clk_en && vld_pipe[1]) begin
        bus.left   <= g_l;
        bus.right  <= g_r;
        bus.clip_l <= g_cl;
        bus.clip_r <= g_cr;
      end
    end
  end
endmodule

// File: tb/tb_jt12_mixacc.sv
// Scoreboard bench: three gain variants share one slot stream; a frame model
// pushes expected L/R/clip, a monitor pops on sample_valid.
module tb_jt12_mixacc;
  localparam int WIN = 14, WOUT = 16, CH = 6, OPS = 4, PCM_CH = 5, PCM_W = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jt12_mixacc_if #(.WIN(WIN), .WOUT(WOUT), .CH(CH), .PCM_W(PCM_W)) bus0 (), bus1 (), bus2 ();

  assign bus1.clk_en = bus0.clk_en;       assign bus2.clk_en = bus0.clk_en;
  assign bus1.zero = bus0.zero;           assign bus2.zero = bus0.zero;
  assign bus1.op_result = bus0.op_result; assign bus2.op_result = bus0.op_result;
  assign bus1.rl = bus0.rl;               assign bus2.rl = bus0.rl;
  assign bus1.alg = bus0.alg;             assign bus2.alg = bus0.alg;
  assign bus1.ch_mute = bus0.ch_mute;     assign bus2.ch_mute = bus0.ch_mute;
  assign bus1.pcm_en = bus0.pcm_en;       assign bus2.pcm_en = bus0.pcm_en;
  assign bus1.pcm = bus0.pcm;             assign bus2.pcm = bus0.pcm;

  jt12_mixacc #(.WIN(WIN), .WOUT(WOUT), .CH(CH), .OPS(OPS), .PCM_CH(PCM_CH), .PCM_W(PCM_W), .GAIN(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  jt12_mixacc #(.WIN(WIN), .WOUT(WOUT), .CH(CH), .OPS(OPS), .PCM_CH(PCM_CH), .PCM_W(PCM_W), .GAIN(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  jt12_mixacc #(.WIN(WIN), .WOUT(WOUT), .CH(CH), .OPS(OPS), .PCM_CH(PCM_CH), .PCM_W(PCM_W), .GAIN(2))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct { int l; int r; bit cl; bit cr; } exp_t;
  exp_t q0[$], q1[$], q2[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampw(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic exp_t apply_gain(input int x, input bit c, input int g);
    exp_t e;
    int y;
    y = (g == 0) ? x : (g == 1) ? x + (x >>> 2) : x + (x >>> 1);
    e.l  = clampw(y);
    e.cl = c | (y != e.l);
    return e;
  endfunction

  // expected frame result for n slots starting at slot 0
  task automatic push_frame(input int n, input int alg, input int opr, input bit [5:0] mute,
                            input bit [1:0] rl, input bit pen, input int pcmv);
    int al, ar, v, op, ch, t;
    bit cl, cr, car;
    exp_t el, er, e;
    al = 0; ar = 0; cl = 0; cr = 0;
    for (int i = 0; i < n; i++) begin
      op = (i % 24) / 6;
      ch = i % 6;
      case (alg)
        0, 1, 2, 3: car = (op == 3);
        4:          car = (op >= 2);
        5, 6:       car = (op != 0);
        default:    car = 1'b1;
      endcase
      if (pen && ch == PCM_CH) v = (op == 0) ? pcmv * 32 : 0;
      else                     v = car ? opr : 0;
      if (mute[ch]) v = 0;
      if (rl[1]) begin t = al + v; al = clampw(t); cl |= (t != al); end
      if (rl[0]) begin t = ar + v; ar = clampw(t); cr |= (t != ar); end
    end
    for (int g = 0; g < 3; g++) begin
      el = apply_gain(al, cl, g);
      er = apply_gain(ar, cr, g);
      e.l = el.l; e.cl = el.cl; e.r = er.l; e.cr = er.cl;
      if (g == 0) q0.push_back(e);
      else if (g == 1) q1.push_back(e);
      else q2.push_back(e);
    end
  endtask

  // one active slot per call iteration, with occasional clk_en-low junk cycles
  task automatic drive_slots(input int n, input bit first_zero, input int alg, input int opr,
                             input bit [5:0] mute, input bit [1:0] rl, input bit pen, input int pcmv);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus0.clk_en    = 1'b0;
        bus0.zero      = 1'($urandom_range(0, 1));
        bus0.op_result = WIN'($urandom);
        @(posedge clk); #1;
      end
      bus0.clk_en    = 1'b1;
      bus0.zero      = first_zero && (i == 0);
      bus0.op_result = WIN'(opr);
      bus0.alg       = 3'(alg);
      bus0.ch_mute   = mute;
      bus0.rl        = rl;
      bus0.pcm_en    = pen;
      bus0.pcm       = PCM_W'(pcmv);
      @(posedge clk); #1;
    end
    bus0.clk_en = 1'b0;
    bus0.zero   = 1'b0;
  endtask

  task automatic run_frame(input int n, input int alg, input int opr, input bit [5:0] mute,
                           input bit [1:0] rl, input bit pen, input int pcmv);
    push_frame(n, alg, opr, mute, rl, pen, pcmv);
    drive_slots(n, 1'b1, alg, opr, mute, rl, pen, pcmv);
  endtask

  task automatic chk_zero_out(input string tag);
    chk({tag, "_l0"}, bus0.left, 0);   chk({tag, "_r0"}, bus0.right, 0);
    chk({tag, "_l1"}, bus1.left, 0);   chk({tag, "_l2"}, bus2.left, 0);
    chk({tag, "_v"}, bus0.sample_valid, 0);
    chk({tag, "_cl"}, bus0.clip_l, 0); chk({tag, "_cr"}, bus0.clip_r, 0);
  endtask

  initial begin : mon
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus0.sample_valid) begin
        chk("vld_width", prev, 0);
        chk("vld_sync1", bus1.sample_valid, 1);
        chk("vld_sync2", bus2.sample_valid, 1);
        if (q0.size() == 0 || q1.size() == 0 || q2.size() == 0) begin
          chk("spurious_vld", bus0.sample_valid, 0);
        end else begin
          e = q0.pop_front();
          chk("left_g0", bus0.left, e.l);   chk("right_g0", bus0.right, e.r);
          chk("clipl_g0", bus0.clip_l, e.cl); chk("clipr_g0", bus0.clip_r, e.cr);
          e = q1.pop_front();
          chk("left_g1", bus1.left, e.l);   chk("right_g1", bus1.right, e.r);
          chk("clipl_g1", bus1.clip_l, e.cl); chk("clipr_g1", bus1.clip_r, e.cr);
          e = q2.pop_front();
          chk("left_g2", bus2.left, e.l);   chk("right_g2", bus2.right, e.r);
          chk("clipl_g2", bus2.clip_l, e.cl); chk("clipr_g2", bus2.clip_r, e.cr);
        end
      end
      prev = bus0.sample_valid;
    end
  end

  initial begin
    int wait_cyc;
    bus0.clk_en = 1'b0; bus0.zero = 1'b0; bus0.op_result = '0; bus0.rl = 2'b11;
    bus0.alg = 3'd7; bus0.ch_mute = '0; bus0.pcm_en = 1'b0; bus0.pcm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_out("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    push_frame(0, 7, 0, 6'b0, 2'b11, 1'b0, 0);            // empty first frame
    run_frame(24, 7, 100, 6'b0, 2'b11, 1'b0, 0);          // 2400
    run_frame(24, 0, 1000, 6'b0, 2'b11, 1'b0, 0);         // 6000
    run_frame(24, 4, 1000, 6'b0, 2'b11, 1'b0, 0);         // 12000
    run_frame(24, 0, 1000, 6'b000001, 2'b11, 1'b0, 0);    // 5000
    run_frame(24, 7, 8191, 6'b0, 2'b11, 1'b0, 0);         // +sat
    run_frame(24, 7, -8192, 6'b0, 2'b11, 1'b0, 0);        // -sat
    run_frame(24, 7, 0, 6'b0, 2'b11, 1'b0, 0);            // clip cleared
    run_frame(24, 7, 0, 6'b0, 2'b10, 1'b1, 100);          // pcm 3200 left only
    run_frame(24, 7, 50, 6'b0, 2'b11, 1'b1, -3);          // pcm replaces ch5 data
    run_frame(24, 7, 0, 6'b0, 2'b10, 1'b0, 100);          // pcm off
    run_frame(24, 0, 1000, 6'b110000, 2'b11, 1'b0, 0);    // 4000
    run_frame(24, 0, -1000, 6'b110000, 2'b11, 1'b0, 0);   // -4000
    run_frame(24, 7, 1250, 6'b0, 2'b11, 1'b0, 0);         // 30000
    run_frame(10, 7, 100, 6'b0, 2'b11, 1'b0, 0);          // early zero
    run_frame(24, 0, 1000, 6'b0, 2'b11, 1'b0, 0);         // resynced
    for (int k = 0; k < 4; k++)
      run_frame(24, int'($urandom_range(0, 7)), int'($urandom_range(0, 16383)) - 8192,
                6'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(0, 511)) - 256);

    // mid-frame reset: previous frame's output is pending when reset hits
    run_frame(24, 7, 100, 6'b0, 2'b11, 1'b0, 0);
    run_frame(24, 7, 100, 6'b0, 2'b11, 1'b0, 0);
    drive_slots(2, 1'b1, 7, 300, 6'b0, 2'b11, 1'b0, 0);
    chk("pre_rst_left", bus0.left, 2400);
    rst_n = 1'b0;
    #1;
    chk_zero_out("midrst");
    q0.delete(); q1.delete(); q2.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_frame(0, 7, 0, 6'b0, 2'b11, 1'b0, 0);
    drive_slots(30, 1'b0, 7, 0, 6'b0, 2'b11, 1'b0, 0);    // no zero: no output
    run_frame(24, 7, 100, 6'b0, 2'b11, 1'b0, 0);
    drive_slots(3, 1'b1, 7, 0, 6'b0, 2'b11, 1'b0, 0);     // close last frame

    wait_cyc = 0;
    while (q0.size() != 0 && wait_cyc < 200) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    chk("drain", q0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/jt12_mixacc.md
# jt12_mixacc

Parametrised stereo channel accumulator for the FM synth output path. Consumes the time-multiplexed operator slot stream (OPS slots per channel, CH channels per frame), sums carrier operators per each channel's algorithm, and substitutes a PCM sample on a designated channel. It applies a saturating limiter on every addition and an optional output gain, then presents one left/right sample pair per frame with a valid strobe. It sits between the operator pipeline and the DAC/resampler.

## Interface
- WIN, 14, operator result width (signed), WIN <= WOUT
- WOUT, 16, accumulator/output width (signed)
- CH, 6, channels per frame
- OPS, 4, operator slots per channel
- PCM_CH, 5, channel index replaced by PCM when enabled
- PCM_W, 9, PCM sample width (signed), PCM_W <= WIN
- GAIN, 1, output gain: 0 = ×1, 1 = ×1.25, 2 = ×1.5

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clk_en  in  1  slot advance enable; all state changes only when high (except reset)
- zero  in  1  marks slot 0 of a frame, qualified by clk_en
- op_result  in  WIN  signed operator output for current slot
- rl  in  2  [1] left enable, [0] right enable, for current slot's channel
- alg  in  3  algorithm of current slot's channel
- ch_mute  in  CH  per-channel mute mask, 1 = excluded from both sums
- pcm_en  in  1  PCM replaces channel PCM_CH
- pcm  in  PCM_W  signed PCM sample
- left, right  out  WOUT  signed frame sums after gain
- sample_valid  out  1  one-clk pulse when left/right update
- clip_l, clip_r  out  1  saturation occurred in the frame just output

## Operation
- Slot counter s in 0..CH*OPS-1: loads 1 on clk_en&zero (current slot is 0), else increments on clk_en, wraps to 0 after CH*OPS-1. Decode: op = s / CH, ch = s % CH (op-major). op order 0..3 = S1,S3,S2,S4.
- Carrier rule (sum_en): alg 0–3: S4 only; alg 4: S2,S4; alg 5,6: all except S1; alg 7: all. For OPS≠4, only op=OPS-1 carries on alg 0–3 and all ops carry on other algs.
- Contribution: op_result sign-extended to WOUT when sum_en & ~ch_mute[ch].
- PCM: if pcm_en & ch==PCM_CH, operator data ignored; contribution = {pcm, (WIN-PCM_W) zeros} sign-extended, added only at op=0 of that channel; remaining slots of that channel add 0. ch_mute and rl still apply.
- Left adds when rl[1], right when rl[0]; otherwise 0.
- Each addition saturates to [-2^(WOUT-1), 2^(WOUT-1)-1]; any saturation sets that side's frame clip flag.
- On clk_en&zero: the finished frame's totals and clip flags move to the output stage; accumulators reload with slot 0 contribution only; frame clip flags reload from slot 0.
- Gain: GAIN=1: y = x + (x>>>2); GAIN=2: y = x + (x>>>1); saturated to WOUT (sets clip for that output). Uses the new frame total, never the previous output.
- A frame that wraps without zero produces no output; accumulation continues.

## Timing
- Reset (async assert, sync release): left, right = 0; sample_valid, clip_l, clip_r = 0; accumulators, clip flags, slot counter = 0.
- Latency: left/right/clip update on the 2nd clk_en edge after the clk_en&zero edge closing the frame; sample_valid high for exactly that one clk cycle.
- Outputs hold between updates.
- zero arriving early (s≠CH*OPS-1) still closes the frame and resyncs the counter; partial frame is output.
- First zero after reset outputs 0 with valid (empty frame).
- rst_n assert mid-frame discards partial sums and a pending output.

## Test plan
- CH=6, OPS=4, GAIN=0, alg=7, rl=11, op_result=100 all 24 slots, zero at slot 0 -> left=right=2400, sample_valid one pulse per frame, clips 0.
- alg=0, op_result=1000 all slots -> 6000 (slots 18–23 only); alg=4 -> 12000; ch_mute=6'b000001 with alg=0 -> 5000.
- alg=7, op_result=8191 all slots -> left=32767, clip_l=1; op_result=-8192 -> -32768, clip=1; next frame op_result=0 -> 0, clip cleared.
- pcm_en=1, pcm=100, PCM_CH=5, op_result=0, rl=10 -> left=3200 (counted once), right=0; pcm_en=0 -> left=0.
- GAIN=1: frame sum 4000 -> 5000, -4000 -> -5000, 30000 -> 32767 with clip; GAIN=2: 4000 -> 6000.
- rst_n low mid-frame -> all outputs 0 immediately; no valid until next zero; early zero at slot 10 -> partial sum output, counter resynced.
